// File: rtl/fetch_resp.sv
// fetch_resp: instruction-fetch responder with a loadable word memory.
//
// A request is accepted when req_valid && req_ready. The memory is read on
// the accepting edge into a single pipeline register. On the next edge that
// register is pushed into a 3-entry response FIFO. The FIFO head drives the
// rsp_* outputs, so a lone request can be taken by the consumer two edges
// after it was accepted.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst_n      - synchronous active-low reset (the memory array is not reset)
//   req_valid  - a fetch byte address is offered on req_addr
//   req_ready  - registered; 1 while fewer than 3 fetches are outstanding
//   req_addr   - fetch byte address
//   rsp_valid  - the response FIFO is not empty
//   rsp_ready  - the consumer takes the head response
//   rsp_data   - head instruction word (0 on error or when the FIFO is empty)
//   rsp_err    - head fetch was misaligned or out of range
//   we         - memory load strobe
//   waddr      - word index to load
//   wdata      - word to load
module fetch_resp #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = '0,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] r_mem [MEM_WORDS];

    // Stage 1: memory word read on the accepting edge.
    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    logic        r_s1_err;

    // Response FIFO.
    logic [31:0] r_fifo_data [3];
    logic        r_fifo_err  [3];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [1:0]  r_count;

    logic [1:0]  r_out;
    logic        r_req_ready;

    logic [31:0]   w_off;
    logic [29:0]   w_idx;
    logic [AW-1:0] w_ridx;
    logic          w_err;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_out_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Word index is taken modulo 2^32, so addresses below BASE_ADDR wrap to
    // huge indices and are flagged as out of range.
    always_comb begin
        w_off  = req_addr - BASE_ADDR;
        w_idx  = w_off[31:2];
        w_ridx = w_idx[AW-1:0];
        w_err  = (req_addr[1:0] != 2'b00) || (w_idx >= 30'(MEM_WORDS));
    end

    assign w_accept = req_valid && r_req_ready;
    assign w_push   = r_s1_valid;
    assign w_pop    = (r_count != 2'd0) && rsp_ready;

    // Outstanding count covers stage 1 and the FIFO together, so capping it
    // at 3 means the FIFO always has room when stage 1 pushes.
    always_comb begin
        w_out_next = r_out;
        case ({w_accept, w_pop})
            2'b10:   w_out_next = r_out + 2'd1;
            2'b01:   w_out_next = r_out - 2'd1;
            default: w_out_next = r_out;
        endcase
    end

    // The memory is not reset. Reads in stage 1 see the value from before a
    // write on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_err ? '0 : r_mem[w_ridx];
                r_s1_err  <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= r_s1_data;
            r_fifo_err[r_wptr]  <= r_s1_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_req_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_out       <= w_out_next;
            r_req_ready <= (w_out_next != 2'd3);
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = (r_count != 2'd0);
    assign rsp_data  = rsp_valid ? r_fifo_data[r_rptr] : '0;
    assign rsp_err   = rsp_valid ? r_fifo_err[r_rptr]  : 1'b0;

endmodule

// File: tb/tb_fetch_resp.sv
// tb_fetch_resp: directed-vector bench for fetch_resp (default parameters).
module tb_fetch_resp;

    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned AW        = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] s_addr [8];
    logic [31:0] s_data [8];
    logic        s_err  [8];

    fetch_resp #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(32'h0),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .we(we),
        .waddr(waddr),
        .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    // Issue s_addr[0..n-1] on consecutive edges with rsp_ready held 1; each
    // response must appear one edge after its acceptance and transfer next.
    task automatic run_stream(input int n, input string tag);
        rsp_ready = 1'b1;
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                req_valid = 1'b1;
                req_addr  = s_addr[c];
            end else begin
                req_valid = 1'b0;
            end
            step();
            chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
            if (c >= 1) begin
                chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_data"}, rsp_data, s_data[c-1]);
                chk({tag, "_err"}, 32'(rsp_err), 32'(s_err[c-1]));
            end else begin
                chk({tag, "_vld0"}, 32'(rsp_valid), 32'd0);
            end
        end
        req_valid = 1'b0;
        step();
        chk({tag, "_empty"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        bit          stale;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;

        // Reset state.
        step(); step();
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_rdy", 32'(req_ready), 32'd1);

        load(8'd0, 32'h11); load(8'd1, 32'h22); load(8'd2, 32'h33); load(8'd3, 32'h44);
        load(8'd255, 32'hDEADBEEF);

        // Single fetch latency.
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
        chk("lat_n1_vld", 32'(rsp_valid), 32'd0);
        step();
        chk("lat_vld", 32'(rsp_valid), 32'd1);
        chk("lat_data", rsp_data, 32'h11);
        chk("lat_err", 32'(rsp_err), 32'd0);
        step();
        chk("lat_gone", 32'(rsp_valid), 32'd0);

        // Back-to-back fetches.
        s_addr[0] = 32'h0; s_data[0] = 32'h11; s_err[0] = 1'b0;
        s_addr[1] = 32'h4; s_data[1] = 32'h22; s_err[1] = 1'b0;
        s_addr[2] = 32'h8; s_data[2] = 32'h33; s_err[2] = 1'b0;
        s_addr[3] = 32'hC; s_data[3] = 32'h44; s_err[3] = 1'b0;
        run_stream(4, "b2b");

        // Backpressure: 5 offered, 3 accepted, head holds.
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * acc);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        chk("bp_acc", 32'(acc), 32'd3);
        chk("bp_rdy0", 32'(req_ready), 32'd0);
        chk("bp_vld", 32'(rsp_valid), 32'd1);
        chk("bp_head", rsp_data, 32'h11);
        step();
        chk("bp_hold", rsp_data, 32'h11);
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("drain_vld", 32'(rsp_valid), 32'd1);
            chk("drain_data", rsp_data, 32'h11 * 32'(k + 1));
            step();
        end
        chk("drain_empty", 32'(rsp_valid), 32'd0);
        chk("drain_rdy", 32'(req_ready), 32'd1);

        // Error and range boundaries.
        s_addr[0] = 32'h2;        s_data[0] = 32'h0;        s_err[0] = 1'b1;
        s_addr[1] = 32'h400;      s_data[1] = 32'h0;        s_err[1] = 1'b1;
        s_addr[2] = 32'h3FC;      s_data[2] = 32'hDEADBEEF; s_err[2] = 1'b0;
        s_addr[3] = 32'hFFFFFFFC; s_data[3] = 32'h0;        s_err[3] = 1'b1;
        s_addr[4] = 32'h3FF;      s_data[4] = 32'h0;        s_err[4] = 1'b1;
        run_stream(5, "errs");

        // Read-before-write on the accepting edge.
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        we = 1'b1; waddr = 8'd1; wdata = 32'hAA;
        step();
        req_valid = 1'b0; we = 1'b0;
        step();
        chk("rbw_vld", 32'(rsp_valid), 32'd1);
        chk("rbw_old", rsp_data, 32'h22);
        step();
        s_addr[0] = 32'h4; s_data[0] = 32'hAA; s_err[0] = 1'b0;
        run_stream(1, "rbw_new");

        // Reset with two fetches in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0; step();
        req_addr = 32'h8; step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mrst_vld", 32'(rsp_valid), 32'd0);
        chk("mrst_rdy", 32'(req_ready), 32'd0);
        chk("mrst_data", rsp_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mrel_rdy", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) stale = 1'b1;
            step();
        end
        chk("mrel_stale", 32'(stale), 32'd0);
        s_addr[0] = 32'h0; s_data[0] = 32'h11; s_err[0] = 1'b0;
        run_stream(1, "mem_kept");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_resp.md
FETCH_RESP -- requirements
Module: fetch_resp

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256: instruction memory depth in 32-bit words, a power of two from 4 to 4096.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0: byte address of word 0.
REQ-003 The block SHALL have parameter AW, default log2(MEM_WORDS): write-index width.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 1: a fetch address is offered.
REQ-007 The block SHALL have port req_ready, output, 1: a fetch address can be accepted.
REQ-008 The block SHALL have port req_addr, input, 32: fetch byte address.
REQ-009 The block SHALL have port rsp_valid, output, 1: a response is offered.
REQ-010 The block SHALL have port rsp_ready, input, 1: the consumer takes the response.
REQ-011 The block SHALL have port rsp_data, output, 32: instruction word.
REQ-012 The block SHALL have port rsp_err, output, 1: the fetch address was misaligned or out of range.
REQ-013 The block SHALL have port we, input, 1: memory write enable for loading.
REQ-014 The block SHALL have port waddr, input, AW: word index to write.
REQ-015 The block SHALL have port wdata, input, 32: word to write.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 A response SHALL transfer on a rising edge where rsp_valid and rsp_ready are both 1.
REQ-018 Word index SHALL be (req_addr - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-019 rsp_err SHALL be 1 when req_addr[1:0] != 0 or when the index >= MEM_WORDS; rsp_data SHALL then be 0.
REQ-020 Read path SHALL be 2 stages: a request accepted at edge N SHALL make its response visible from edge N+2 when no older response is pending.
REQ-021 Responses SHALL be returned strictly in acceptance order with no loss or duplication.
REQ-022 Completed reads SHALL enter a 3-entry response FIFO; rsp_valid SHALL be 1 when the FIFO is not empty, and rsp_data/rsp_err SHALL show the head entry.
REQ-023 rsp_valid, rsp_data and rsp_err SHALL stay stable while rsp_valid is 1 and rsp_ready is 0.
REQ-024 An outstanding counter (0..3) SHALL count accepted requests not yet transferred: +1 on accept, -1 on response transfer, unchanged when both occur on the same edge.
REQ-025 req_ready SHALL be 1 exactly when outstanding < 3, taken from registered state only (no combinational path from rsp_ready or req_valid).
REQ-026 Throughput SHALL be one request per cycle while rsp_ready is held 1.
REQ-027 The FIFO SHALL never overflow; the counter limit in REQ-025 SHALL guarantee this.
REQ-028 When we is 1 on edge E, mem[waddr] SHALL take wdata.
REQ-029 A read sampling the same word at edge E SHALL return the pre-write value (read-before-write); reads at later edges SHALL return wdata.
REQ-030 req_addr SHALL be ignored when the request is not accepted.

Reset
REQ-031 While rst_n is 0 at a rising edge, the block SHALL set outstanding to 0, empty the FIFO, invalidate both pipeline stages, and drive rsp_valid=0, rsp_err=0, rsp_data=0, req_ready=0.
REQ-032 req_ready SHALL become 1 on the first edge at which rst_n is sampled 1.
REQ-033 Reset during operation SHALL discard all in-flight and buffered responses; none SHALL appear after reset.
REQ-034 Memory contents SHALL NOT be affected by reset.

Verification
REQ-035 Load mem[0..3]=0x11,0x22,0x33,0x44 via we; issue addr 0x0 at edge N with rsp_ready=1 -> rsp_valid=1, rsp_data=0x11, rsp_err=0 from edge N+2.
REQ-036 Back-to-back addrs 0x0,0x4,0x8,0xC with rsp_ready=1 -> req_ready stays 1; data 0x11,0x22,0x33,0x44 on consecutive cycles.
REQ-037 rsp_ready=0 while offering 5 requests -> exactly 3 accepted, then req_ready=0 and the head holds 0x11; raise rsp_ready -> 0x11,0x22,0x33 drain in order and req_ready returns to 1.
REQ-038 Addr 0x2, then addr 4*MEM_WORDS (BASE_ADDR=0) -> two responses, each rsp_err=1 and rsp_data=0.
REQ-039 we=1 with waddr=1, wdata=0xAA on the same edge that accepts addr 0x4 -> response 0x22; a second fetch of 0x4 -> 0xAA.
REQ-040 Pull rst_n low with 2 responses outstanding -> rsp_valid=0 and req_ready=0 during reset; after release, no stale responses; mem[0] still reads 0x11.
